reg_bank_mem: RTL and testbench
===============================

REG_BANK_MEM -- requirements
Module: reg_bank_mem

Interface
REQ-001 Parameter WIDTH, default 256: entry width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be at least 2 and need not be a power of two.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port regEN  input  1: access request, sampled each rising edge.
REQ-007 Port regRW  input  1: 1 = read, 0 = write.
REQ-008 Port regAddr  input  AW: entry address.
REQ-009 Port regWrite  input  WIDTH: write data.
REQ-010 Port regByteEn  input  WIDTH/8: per-byte write enable; bit i covers data bits 8i+7..8i.
REQ-011 Port regClr  input  1: start a clear sweep.
REQ-012 Port regBus  output  WIDTH: read data; holds its value until the next accepted read.
REQ-013 Port regFlag  output  1: one-cycle completion pulse.
REQ-014 Port regErr  output  1: one-cycle error pulse.
REQ-015 Port regBusy  output  1: high while a clear sweep is in progress.

Function
REQ-016 FSM states: IDLE and CLEAR; regBusy SHALL be 1 exactly when in CLEAR.
REQ-017 Accept rule: a request is accepted at edge N when regEN=1, state=IDLE and regClr=0.
REQ-018 An accepted request SHALL raise regFlag for exactly the cycle after edge N; one request per cycle, back-to-back accepted requests yield back-to-back flags.
REQ-019 Write, in-range address: only bytes with regByteEn=1 SHALL be updated at edge N; the entry's valid bit SHALL be set even when regByteEn is all zeros.
REQ-020 Read, in-range and valid: regBus SHALL take the entry contents at edge N, so a read accepted at N+1 returns data written at N.
REQ-021 Read of an entry whose valid bit is 0: regBus SHALL become 0 and regErr SHALL pulse together with regFlag.
REQ-022 regAddr >= DEPTH: a write SHALL change nothing; a read SHALL set regBus to 0; both SHALL pulse regFlag and regErr.
REQ-023 regClr=1 in IDLE: enter CLEAR; a 0..DEPTH-1 sweep counter SHALL zero one entry (data and valid bit) per cycle, then return to IDLE after the entry DEPTH-1 cycle, so regBusy is high for exactly DEPTH cycles.
REQ-024 regClr together with regEN in IDLE: the clear SHALL win; the request is rejected, regErr pulses the next cycle and regFlag stays 0.
REQ-025 regEN=1 while in CLEAR: the request is rejected; regErr SHALL pulse the next cycle, regFlag stays 0, and no entry or regBus change occurs.
REQ-026 regClr while in CLEAR SHALL be ignored; the sweep does not restart.
REQ-027 regBus SHALL change only on an accepted read or on reset; it SHALL NOT change on writes or clear sweeps.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, sweep counter 0, all valid bits 0, regBus 0, regFlag 0, regErr 0, regBusy 0.
REQ-029 Entry data SHALL NOT be reset; invalid entries read as 0 through REQ-021.
REQ-030 rst_n asserted mid-sweep SHALL abort the sweep; after release the block is in IDLE and all entries are invalid.
REQ-031 The first request may be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-032 A shared package reg_bank_pkg SHALL hold the state typedef (IDLE, CLEAR) and the byte-lane width constant 8.
REQ-033 One sub-module, reg_bank_bytewr, SHALL implement the byte-masked merge of old data, new data and regByteEn.
REQ-034 All other logic, including storage, valid bits, FSM and sweep counter, SHALL reside in reg_bank_mem.

Verification
REQ-035 After reset, write addr 3 data 0xA5 repeated, all byte enables -> regFlag one cycle later; read addr 3 next cycle -> regBus=0xA5A5..., regFlag=1, regErr=0.
REQ-036 Write addr 1 data all-ones with regByteEn=0x0001, then read addr 1 -> regBus=0x...00FF (upper bytes 0), regErr=0.
REQ-037 Read of never-written addr 5 -> regBus=0, regFlag=1, regErr=1; with DEPTH=6, read addr 7 -> regBus=0, regFlag=1, regErr=1.
REQ-038 regClr pulse with DEPTH=8 -> regBusy high 8 cycles; regEN during the sweep -> regErr pulse with no regFlag; read addr 3 after the sweep -> regErr=1.
REQ-039 rst_n low at sweep cycle 3 -> all outputs 0 asynchronously; after release a read of a previously written entry -> regErr=1.
REQ-040 regClr and a write to addr 2 in the same cycle -> regErr=1, regFlag=0, sweep runs, entry 2 invalid afterwards.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: FSM state type and byte-lane width.
package reg_bank_pkg;

    localparam int unsigned LANE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_bytewr.sv
// Byte-masked merge: each lane takes new data when its enable is set,
// otherwise keeps the old entry contents.
module reg_bank_bytewr
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 256
) (
    input  logic [WIDTH-1:0]        old_data,
    input  logic [WIDTH-1:0]        new_data,
    input  logic [WIDTH/LANE_W-1:0] byte_en,
    output logic [WIDTH-1:0]        merged
);

    // Per-lane select between old and new data.
    always_comb begin
        merged = old_data;
        for (int unsigned i = 0; i < WIDTH / LANE_W; i++) begin
            if (byte_en[i]) begin
                merged[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/reg_bank_mem.sv
// Register bank with byte-enabled writes, per-entry valid bits, error
// signalling for invalid/out-of-range accesses and a one-entry-per-cycle
// clear sweep.
module reg_bank_mem
    import reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    regEN,
    input  logic                    regRW,
    input  logic [AW-1:0]           regAddr,
    input  logic [WIDTH-1:0]        regWrite,
    input  logic [WIDTH/LANE_W-1:0] regByteEn,
    input  logic                    regClr,
    output logic [WIDTH-1:0]        regBus,
    output logic                    regFlag,
    output logic                    regErr,
    output logic                    regBusy
);

    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    state_t          state;
    logic [AW-1:0]   sweep_cnt;
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] mem [DEPTH];

    logic            in_range;
    logic [AW-1:0]   idx;
    logic            accept;
    logic            reject;
    logic            wr_accept;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] merged;

    assign in_range  = ({1'b0, regAddr} < DEPTH_EXT);
    // Out-of-range addresses are clamped so the storage index is always legal;
    // in_range gates every effect of such an access.
    assign idx       = in_range ? regAddr : '0;
    assign accept    = regEN && (state == IDLE) && !regClr;
    assign reject    = regEN && !((state == IDLE) && !regClr);
    assign wr_accept = accept && !regRW && in_range;
    assign rd_data   = mem[idx];
    assign regBusy   = (state == CLEAR);

    reg_bank_bytewr #(
        .WIDTH (WIDTH)
    ) u_bytewr (
        .old_data (rd_data),
        .new_data (regWrite),
        .byte_en  (regByteEn),
        .merged   (merged)
    );

    // Entry data storage (not reset): sweep zeroing or byte-masked write.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_accept) begin
            mem[idx] <= merged;
        end
    end

    // FSM, sweep counter, valid bits and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            valid     <= '0;
            regBus    <= '0;
            regFlag   <= 1'b0;
            regErr    <= 1'b0;
        end else begin
            regFlag <= accept;
            regErr  <= reject || (accept && (!in_range || (regRW && !valid[idx])));

            case (state)
                IDLE: begin
                    if (regClr) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                    end
                end
                CLEAR: begin
                    valid[sweep_cnt] <= 1'b0;
                    if (sweep_cnt == LAST_IDX) begin
                        state     <= IDLE;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    sweep_cnt <= '0;
                end
            endcase

            if (accept) begin
                if (regRW) begin
                    regBus <= (in_range && valid[idx]) ? rd_data : '0;
                end else if (in_range) begin
                    valid[idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_mem.sv
module tb_reg_bank_mem;

    localparam int W  = 256;
    localparam int D  = 8;
    localparam int W6 = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          regEN, regRW, regClr;
    logic [2:0]    regAddr;
    logic [W-1:0]  regWrite;
    logic [W/8-1:0] regByteEn;
    logic [W-1:0]  regBus;
    logic          regFlag, regErr, regBusy;

    logic          s_en, s_rw, s_clr;
    logic [2:0]    s_addr;
    logic [W6-1:0] s_wdata;
    logic [3:0]    s_be;
    logic [W6-1:0] s_bus;
    logic          s_flag, s_err, s_busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_mem [D];
    bit           m_valid [D];
    logic [W-1:0] m_bus;
    int           busy_left;
    logic         e_flag, e_err, e_busy;

    always #5 clk = ~clk;

    reg_bank_mem #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .regEN(regEN), .regRW(regRW),
        .regAddr(regAddr), .regWrite(regWrite), .regByteEn(regByteEn),
        .regClr(regClr), .regBus(regBus), .regFlag(regFlag),
        .regErr(regErr), .regBusy(regBusy)
    );

    reg_bank_mem #(.WIDTH(W6), .DEPTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .regEN(s_en), .regRW(s_rw),
        .regAddr(s_addr), .regWrite(s_wdata), .regByteEn(s_be),
        .regClr(s_clr), .regBus(s_bus), .regFlag(s_flag),
        .regErr(s_err), .regBusy(s_busy)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_valid[i] = 0;
        m_bus = '0; busy_left = 0; e_flag = 0; e_err = 0; e_busy = 0;
    endtask

    task automatic model_step(input logic en, input logic rw, input logic [2:0] addr,
                              input logic [W-1:0] data, input logic [W/8-1:0] be, input logic clr);
        logic [W-1:0] mask;
        e_flag = 0; e_err = 0;
        if (busy_left > 0) begin
            if (en) e_err = 1;
            m_mem[D - busy_left]   = '0;
            m_valid[D - busy_left] = 0;
            busy_left--;
        end else if (clr) begin
            busy_left = D;
            if (en) e_err = 1;
        end else if (en) begin
            e_flag = 1;
            if (int'(addr) >= D) begin
                e_err = 1;
                if (rw) m_bus = '0;
            end else if (rw) begin
                if (m_valid[addr]) m_bus = m_mem[addr];
                else begin m_bus = '0; e_err = 1; end
            end else begin
                for (int b = 0; b < W/8; b++) mask[b*8 +: 8] = {8{be[b]}};
                m_mem[addr]   = (m_mem[addr] & ~mask) | (data & mask);
                m_valid[addr] = 1;
            end
        end
        e_busy = (busy_left > 0);
    endtask

    task automatic apply(input logic en, input logic rw, input logic [2:0] addr,
                         input logic [W-1:0] data, input logic [W/8-1:0] be, input logic clr);
        @(negedge clk);
        regEN = en; regRW = rw; regAddr = addr; regWrite = data; regByteEn = be; regClr = clr;
        model_step(en, rw, addr, data, be, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " bus"},  regBus,  m_bus);
        check({tag, " flag"}, W'(regFlag), W'(e_flag));
        check({tag, " err"},  W'(regErr),  W'(e_err));
        check({tag, " busy"}, W'(regBusy), W'(e_busy));
    endtask

    task automatic apply6(input logic en, input logic rw, input logic [2:0] addr,
                          input logic [W6-1:0] data, input logic [3:0] be);
        @(negedge clk);
        s_en = en; s_rw = rw; s_addr = addr; s_wdata = data; s_be = be;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < W/32; i++) d = {d[W-33:0], $urandom()};
        return d;
    endfunction

    typedef struct {
        logic          en, rw;
        logic [2:0]    addr;
        logic [W-1:0]  data;
        logic [W/8-1:0] be;
        logic          clr;
        logic          exp_flag, exp_err;
        logic [W-1:0]  exp_bus;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a5, ones, ff;
        int busy_cnt;
        a5   = {32{8'hA5}};
        ones = '1;
        ff   = W'(8'hFF);

        vecs[0] = '{1, 0, 3, a5,   '1,          0, 1, 0, '0};
        vecs[1] = '{1, 1, 3, '0,   '0,          0, 1, 0, a5};
        vecs[2] = '{1, 0, 1, '0,   '1,          0, 1, 0, a5};
        vecs[3] = '{1, 0, 1, ones, 32'h0000_0001, 0, 1, 0, a5};
        vecs[4] = '{1, 1, 1, '0,   '0,          0, 1, 0, ff};
        vecs[5] = '{1, 1, 5, '0,   '0,          0, 1, 1, '0};
        vecs[6] = '{1, 0, 1, ones, '0,          0, 1, 0, '0};
        vecs[7] = '{1, 1, 1, '0,   '0,          0, 1, 0, ff};
        vecs[8] = '{0, 1, 3, '0,   '0,          0, 0, 0, ff};
        vecs[9] = '{1, 1, 3, '0,   '0,          0, 1, 0, a5};

        for (int i = 0; i < D; i++) m_mem[i] = '0;
        model_reset();
        rst_n = 0;
        regEN = 0; regRW = 0; regAddr = '0; regWrite = '0; regByteEn = '0; regClr = 0;
        s_en = 0; s_rw = 0; s_addr = '0; s_wdata = '0; s_be = '0; s_clr = 0;
        #1;
        check("reset bus",  regBus, '0);
        check("reset flag", W'(regFlag), '0);
        check("reset err",  W'(regErr), '0);
        check("reset busy", W'(regBusy), '0);
        #11 rst_n = 1;

        // DEPTH=6 instance: out-of-range and boundary addresses
        apply6(1, 1, 7, '0, '0);
        check("d6 rd7 bus", W'(s_bus), '0);
        check("d6 rd7 flag", W'(s_flag), W'(1));
        check("d6 rd7 err", W'(s_err), W'(1));
        apply6(1, 0, 6, 32'hDEAD_BEEF, '1);
        check("d6 wr6 flag", W'(s_flag), W'(1));
        check("d6 wr6 err", W'(s_err), W'(1));
        apply6(1, 0, 5, 32'h1234_5678, '1);
        check("d6 wr5 err", W'(s_err), W'(0));
        apply6(1, 1, 5, '0, '0);
        check("d6 rd5 bus", W'(s_bus), W'(32'h1234_5678));
        check("d6 rd5 err", W'(s_err), W'(0));
        apply6(1, 1, 6, '0, '0);
        check("d6 rd6 bus", W'(s_bus), '0);
        check("d6 rd6 err", W'(s_err), W'(1));
        apply6(0, 0, 0, '0, '0);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].clr);
            check($sformatf("vec%0d bus", i),  regBus, vecs[i].exp_bus);
            check($sformatf("vec%0d flag", i), W'(regFlag), W'(vecs[i].exp_flag));
            check($sformatf("vec%0d err", i),  W'(regErr),  W'(vecs[i].exp_err));
        end

        // Clear sweep: busy duration and requests rejected during the sweep
        apply(0, 0, 0, '0, '0, 1);
        check_model("clr start");
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!regBusy) break;
            busy_cnt++;
            if (k == 2) begin
                apply(1, 1, 3, '0, '0, 0);
                check("sweep req err", W'(regErr), W'(1));
                check("sweep req flag", W'(regFlag), W'(0));
                check("sweep req bus", regBus, a5);
            end else if (k == 4) begin
                apply(0, 0, 0, '0, '0, 1);
            end else begin
                apply(0, 0, 0, '0, '0, 0);
            end
            check_model($sformatf("sweep k%0d", k));
        end
        check("busy cycles", W'(busy_cnt), W'(8));
        apply(1, 1, 3, '0, '0, 0);
        check("post sweep rd3 err", W'(regErr), W'(1));
        check("post sweep rd3 bus", regBus, '0);

        // Clear and write in the same cycle: clear wins
        apply(1, 0, 2, a5, '1, 0);
        check_model("pre clr wr2");
        apply(1, 0, 2, ones, '1, 1);
        check("clr+wr err", W'(regErr), W'(1));
        check("clr+wr flag", W'(regFlag), W'(0));
        check("clr+wr busy", W'(regBusy), W'(1));
        for (int k = 0; k < 20 && regBusy; k++) begin
            apply(0, 0, 0, '0, '0, 0);
            check_model("clr+wr sweep");
        end
        apply(1, 1, 2, '0, '0, 0);
        check("clr+wr rd2 err", W'(regErr), W'(1));

        // Reset in the middle of a sweep
        apply(1, 0, 4, a5, '1, 0);
        apply(1, 1, 4, '0, '0, 0);
        check_model("pre rst rd4");
        apply(0, 0, 0, '0, '0, 1);
        apply(0, 0, 0, '0, '0, 0);
        apply(0, 0, 0, '0, '0, 0);
        apply(0, 0, 0, '0, '0, 0);
        check("pre rst busy", W'(regBusy), W'(1));
        #2 rst_n = 0;
        #1;
        check("async rst bus",  regBus, '0);
        check("async rst flag", W'(regFlag), '0);
        check("async rst err",  W'(regErr), '0);
        check("async rst busy", W'(regBusy), '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        apply(1, 1, 4, '0, '0, 0);
        check_model("post rst rd4");
        check("post rst rd4 err", W'(regErr), W'(1));

        // Full sweep so every entry's data is known to the model
        apply(0, 0, 0, '0, '0, 1);
        for (int k = 0; k < 20 && regBusy; k++) apply(0, 0, 0, '0, '0, 0);
        check_model("init sweep");

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic en, rw, clr;
            logic [2:0] addr;
            logic [W/8-1:0] be;
            en   = ($urandom_range(0, 9) < 7);
            rw   = $urandom_range(0, 1);
            clr  = ($urandom_range(0, 49) == 0);
            addr = 3'($urandom_range(0, 7));
            be   = (($urandom_range(0, 3) == 0) ? '1 : $urandom());
            apply(en, rw, addr, rand_data(), be, clr);
            check_model($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
